// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: command tags, opcodes and
// the sequencer state encoding.
package alu_pkg;

  localparam logic [1:0] TAG_LOAD_A = 2'b00;
  localparam logic [1:0] TAG_LOAD_B = 2'b01;
  localparam logic [1:0] TAG_GO     = 2'b10;
  localparam logic [1:0] TAG_REPEAT = 2'b11;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } state_t;

  // Unary operations only consume operand A, so they do not need B loaded.
  function automatic logic is_unary(input logic [2:0] op);
    logic unary;
    unary = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: unary = 1'b0;
      OP_NOT, OP_SHR, OP_SHL:                unary = 1'b1;
      default:                               unary = 1'b0;
    endcase
    return unary;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Assembles A, B and opcode from a byte-wide command stream and issues one
// complete operation at a time to the ALU over a valid/ready handshake.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int CODEW = 3,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OPW-1:0]   alu_a,
  output logic [OPW-1:0]   alu_b,
  output logic [CODEW-1:0] alu_op,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic [CNTW-1:0]  issue_cnt,
  output logic             cmd_err
);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_alu_valid;
  logic [OPW-1:0]   r_a;
  logic [OPW-1:0]   r_b;
  logic [CODEW-1:0] r_op;
  logic             r_a_ok;
  logic             r_b_ok;
  logic             r_go_seen;
  logic [CNTW-1:0]  r_issue_cnt;
  logic             r_cmd_err;

  logic [1:0]       w_tag;
  logic [5:0]       w_payload;
  logic [CODEW-1:0] w_go_op;
  logic             w_accept;
  logic             w_go_ok;
  logic             w_unused_payload;

  assign w_tag     = in_data[7:6];
  assign w_payload = in_data[5:0];
  assign w_go_op   = w_payload[CODEW-1:0];
  assign w_accept  = in_valid && r_in_ready;
  assign w_go_ok   = r_a_ok && (is_unary(w_go_op) || r_b_ok);

  // Payload bits above the operand field carry no meaning.
  assign w_unused_payload = &{1'b0, w_payload[5:OPW]};

  // NOTE: every register, including the operand storage, is cleared by the
  // async reset so outputs read 0 during reset; all state uses <= so each
  // branch sees the pre-edge values, and a later <= overrides an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_in_ready  <= 1'b0;
      r_alu_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_a_ok      <= 1'b0;
      r_b_ok      <= 1'b0;
      r_go_seen   <= 1'b0;
      r_issue_cnt <= '0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      case (r_state)
        COLLECT: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            case (w_tag)
              TAG_LOAD_A: begin
                r_a    <= w_payload[OPW-1:0];
                r_a_ok <= 1'b1;
              end
              TAG_LOAD_B: begin
                r_b    <= w_payload[OPW-1:0];
                r_b_ok <= 1'b1;
              end
              TAG_GO: begin
                if (w_go_ok) begin
                  r_op        <= w_go_op;
                  r_go_seen   <= 1'b1;
                  r_state     <= ISSUE;
                  r_alu_valid <= 1'b1;
                  r_in_ready  <= 1'b0;
                end else begin
                  r_cmd_err <= 1'b1;
                end
              end
              TAG_REPEAT: begin
                // Reuses the opcode of the last successful GO with current operands.
                if (r_go_seen) begin
                  r_state     <= ISSUE;
                  r_alu_valid <= 1'b1;
                  r_in_ready  <= 1'b0;
                end else begin
                  r_cmd_err <= 1'b1;
                end
              end
              default: r_cmd_err <= 1'b0;
            endcase
          end
        end
        ISSUE: begin
          if (alu_ready) begin
            r_state     <= COLLECT;
            r_alu_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= COLLECT;
          r_alu_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign alu_valid = r_alu_valid;
  assign issue_cnt = r_issue_cnt;
  assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a command-level model predicts
// issued operations and rejections; a negedge monitor compares DUT output.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_valid;
  logic       alu_ready = 1'b0;
  logic [7:0] issue_cnt;
  logic       cmd_err;

  alu_cmd_sequencer #(.OPW(4), .CODEW(3), .CNTW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .issue_cnt (issue_cnt),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: what the command stream has established so far.
  logic [3:0] m_a, m_b;
  logic [2:0] m_last_op;
  bit         m_a_ok, m_b_ok, m_go_seen;
  int         m_cnt;

  int ready_mode = 0;  // 0: alu_ready low, 1: high, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_a = 4'h0; m_b = 4'h0; m_last_op = 3'h0;
    m_a_ok = 1'b0; m_b_ok = 1'b0; m_go_seen = 1'b0;
    m_cnt = 0;
    exp_q.delete();
  endfunction

  function automatic void push_issue(input logic [2:0] op);
    exp_t e;
    e.is_err = 1'b0; e.a = m_a; e.b = m_b; e.op = op; e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
    m_cnt = (m_cnt + 1) % 256;
  endfunction

  function automatic void push_err();
    exp_t e;
    e.is_err = 1'b1; e.a = 4'h0; e.b = 4'h0; e.op = 3'h0; e.cnt = 8'h00;
    exp_q.push_back(e);
  endfunction

  function automatic void model_accept(input logic [7:0] d);
    logic [5:0] p;
    logic [2:0] op;
    p  = d[5:0];
    op = p[2:0];
    case (d[7:6])
      2'b00: begin m_a = p[3:0]; m_a_ok = 1'b1; end
      2'b01: begin m_b = p[3:0]; m_b_ok = 1'b1; end
      2'b10: begin
        if (m_a_ok && (op >= 3'd5 || m_b_ok)) begin
          m_last_op = op;
          m_go_seen = 1'b1;
          push_issue(op);
        end else begin
          push_err();
        end
      end
      default: begin
        if (m_go_seen) push_issue(m_last_op);
        else           push_err();
      end
    endcase
  endfunction

  // Present a command and hold it until an edge where in_ready was high.
  task automatic send(input logic [7:0] d, output int cycles);
    logic rdy;
    cycles = 0;
    rdy = 1'b0;
    in_data = d;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      cycles++;
    end while (!rdy && cycles < 64);
    if (!rdy) check("send_timeout", {31'b0, rdy}, 32'd1);
    else      model_accept(d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    #1;
    if (exp_q.size() != 0) check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       alu_ready = 1'b0;
        1:       alu_ready = 1'b1;
        default: alu_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every DUT event is matched against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cmd_err) begin
          if (exp_q.size() == 0 || !exp_q[0].is_err) begin
            check("cmd_err_unexpected", {31'b0, cmd_err}, 32'd0);
          end else begin
            check("err_alu_valid", {31'b0, alu_valid}, 32'd0);
            void'(exp_q.pop_front());
          end
        end
        if (alu_valid) begin
          if (exp_q.size() == 0 || exp_q[0].is_err) begin
            check("alu_valid_unexpected", {31'b0, alu_valid}, 32'd0);
          end else begin
            check("alu_a", {28'b0, alu_a}, {28'b0, exp_q[0].a});
            check("alu_b", {28'b0, alu_b}, {28'b0, exp_q[0].b});
            check("alu_op", {29'b0, alu_op}, {29'b0, exp_q[0].op});
            check("issue_in_ready", {31'b0, in_ready}, 32'd0);
            if (alu_ready) begin
              check("issue_cnt_pre", {24'b0, issue_cnt}, {24'b0, exp_q[0].cnt});
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    model_reset();

    // Reset state and release timing.
    #23;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_alu_valid", {31'b0, alu_valid}, 32'd0);
    check("rst_alu_a", {28'b0, alu_a}, 32'd0);
    check("rst_alu_b", {28'b0, alu_b}, 32'd0);
    check("rst_alu_op", {29'b0, alu_op}, 32'd0);
    check("rst_issue_cnt", {24'b0, issue_cnt}, 32'd0);
    check("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready_first", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("release_in_ready_second", {31'b0, in_ready}, 32'd1);

    // REPEAT before any GO, then missing-operand GO, then a unary GO.
    ready_mode = 0;
    send(8'hC0, c);
    send(8'h03, c);
    send(8'h81, c);
    send(8'h85, c);
    tick(3);
    check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    check("hold_alu_valid", {31'b0, alu_valid}, 32'd1);
    ready_mode = 1;
    wait_idle();
    ready_mode = 0;
    tick(1);
    check("cnt_after_not", {24'b0, issue_cnt}, m_cnt);

    // Binary op with stall; loads back-to-back without bubbles.
    send(8'h03, c);
    send(8'h45, c);
    check("b2b_load_cycles", c, 32'd1);
    send(8'h80, c);
    tick(3);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    check("stall_alu_a", {28'b0, alu_a}, 32'd3);
    ready_mode = 1;
    wait_idle();
    ready_mode = 0;
    tick(1);
    check("cnt_after_add", {24'b0, issue_cnt}, m_cnt);
    check("in_ready_after_add", {31'b0, in_ready}, 32'd1);

    // REPEAT with a fresh A reuses B and the ADD opcode.
    send(8'h0F, c);
    send(8'hC0, c);
    ready_mode = 1;
    wait_idle();

    // Randomised command stream with random ALU back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      send(8'($urandom), c);
      if ($urandom_range(0, 7) == 0) tick(int'($urandom_range(1, 3)));
    end
    ready_mode = 1;
    wait_idle();

    // Counter wrap with alu_ready tied high; GOs must land 2 cycles apart.
    do_reset();
    send(8'h01, c);
    send(8'h42, c);
    for (int i = 0; i < 256; i++) begin
      send(8'h80 | 8'(i % 8), c);
      if (i > 0) check("go_spacing", c, 32'd2);
    end
    wait_idle();
    tick(1);
    check("cnt_wrap", {24'b0, issue_cnt}, m_cnt);

    // Reset while an operation is presented.
    ready_mode = 0;
    send(8'h80, c);
    @(posedge clk);
    #2;
    check("pre_reset_valid", {31'b0, alu_valid}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_valid_drop", {31'b0, alu_valid}, 32'd0);
    check("async_cnt_clear", {24'b0, issue_cnt}, 32'd0);
    check("async_in_ready", {31'b0, in_ready}, 32'd0);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    send(8'h80, c);
    wait_idle();

    tick(3);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
